// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for the SRAM slave: address/data phase
// signals from the bus controller and the slave's response signals.
interface ahb_sram_slave_if;
  logic        sel;
  logic        write;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [1:0]  trans;
  logic        ready_in;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready_out;
  logic        resp;

  modport master (
    output sel, write, addr, size, trans, ready_in, wdata,
    input  rdata, ready_out, resp
  );

  modport slave (
    input  sel, write, addr, size, trans, ready_in, wdata,
    output rdata, ready_out, resp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised single-port memory with byte/half/word
// access, optional wait states, two-cycle ERROR response for illegal accesses
// and write-to-read forwarding for back-to-back pipelined transfers.
module ahb_sram_slave #(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  ahb_sram_slave_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS * 4);
  localparam int          IW        = AW - 2;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS * 4);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  // Byte lanes touched by a transfer of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Natural alignment for the legal sizes; any other size is never aligned.
  function automatic logic is_aligned(input logic [2:0] sz, input logic [1:0] a);
    logic ok;
    case (sz)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~a[0];
      3'd2:    ok = (a == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [2:0]    wcnt_q;
  logic          wr_p1;
  logic [IW-1:0] idx_p1;
  logic [3:0]    be_p1;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          can_accept;
  logic          accept;
  logic          legal;
  logic [31:0]   offset;
  logic [IW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic          commit;
  logic          ld_direct;
  logic          ld_wait;
  logic          ld_rdata;
  logic [IW-1:0] rd_idx;
  logic [31:0]   fwd_word;

  // Address-phase decode: acceptance, legality, word index and lane mask.
  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    accept     = can_accept && bus.sel && bus.ready_in &&
                 ((bus.trans == TR_NONSEQ) || (bus.trans == TR_SEQ));
    offset     = bus.addr - BASE;
    legal      = (bus.size <= 3'd2) && is_aligned(bus.size, bus.addr[1:0]) &&
                 ({1'b0, offset} < MEM_BYTES);
    acc_idx    = offset[AW-1:2];
    acc_be     = lane_mask(bus.size, bus.addr[1:0]);
  end

  // Next-state selection for the transfer FSM.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          if (!legal)                state_d = ST_ERR1;
          else if (WAIT_STATES > 0)  state_d = ST_WAIT;
          else                       state_d = ST_DATA;
        end
      end
      ST_WAIT: state_d = (wcnt_q == 3'd0) ? ST_DATA : ST_WAIT;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read capture and forwarding: rdata is loaded at the edge entering a read
  // DATA cycle; lanes being committed by a write on that same edge are merged in.
  always_comb begin
    commit    = (state_q == ST_DATA) && wr_p1 && !rst;
    ld_direct = accept && legal && !bus.write && (WAIT_STATES == 0);
    ld_wait   = (state_q == ST_WAIT) && (wcnt_q == 3'd0) && !wr_p1;
    ld_rdata  = ld_direct || ld_wait;
    rd_idx    = ld_direct ? acc_idx : idx_p1;
    fwd_word  = mem[rd_idx];
    if (commit && (idx_p1 == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) fwd_word[8*b +: 8] = bus.wdata[8*b +: 8];
      end
    end
  end

  // Control state: FSM, wait counter, transfer direction and read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
      wr_p1   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_p1  <= bus.write;
        wcnt_q <= (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
      end else if ((state_q == ST_WAIT) && (wcnt_q != 3'd0)) begin
        wcnt_q <= wcnt_q - 3'd1;
      end
      if (ld_rdata) rdata_q <= fwd_word;
    end
  end

  // Address-phase payload carried into the data phase (no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p1 <= acc_idx;
      be_p1  <= acc_be;
    end
  end

  // SRAM write port: commit only the selected byte lanes at the end of DATA.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) mem[idx_p1][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ready_out = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign bus.resp      = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (0, 3 and 2 wait states)
// share one stimulus set; sel is steered to the instance under test.
module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  size = 3'd0;
  logic [1:0]  trans = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  tgt = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if b0 ();
  ahb_sram_slave_if b1 ();
  ahb_sram_slave_if b2 ();

  assign b0.sel = sel && (tgt == 2'd0);
  assign b1.sel = sel && (tgt == 2'd1);
  assign b2.sel = sel && (tgt == 2'd2);
  assign b0.write = write;  assign b1.write = write;  assign b2.write = write;
  assign b0.addr  = addr;   assign b1.addr  = addr;   assign b2.addr  = addr;
  assign b0.size  = size;   assign b1.size  = size;   assign b2.size  = size;
  assign b0.trans = trans;  assign b1.trans = trans;  assign b2.trans = trans;
  assign b0.wdata = wdata;  assign b1.wdata = wdata;  assign b2.wdata = wdata;
  assign b0.ready_in = b0.ready_out;
  assign b1.ready_in = b1.ready_out;
  assign b2.ready_in = b2.ready_out;

  ahb_sram_slave #(.BASE(32'h0), .DEPTH_WORDS(512), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(b0));
  ahb_sram_slave #(.BASE(32'h0), .DEPTH_WORDS(512), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(b1));
  ahb_sram_slave #(.BASE(32'h0), .DEPTH_WORDS(512), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst(rst), .bus(b2));

  logic        rdy;
  logic        rsp;
  logic [31:0] rdo;

  always_comb begin
    rdy = b0.ready_out;
    rsp = b0.resp;
    rdo = b0.rdata;
    case (tgt)
      2'd1:    begin rdy = b1.ready_out; rsp = b1.resp; rdo = b1.rdata; end
      2'd2:    begin rdy = b2.ready_out; rsp = b2.resp; rdo = b2.rdata; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Non-pipelined transfer; called just after a rising edge, returns just after one.
  task automatic single(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic rs, output int lows);
    sel = 1'b1; trans = 2'd2; write = w; addr = a; size = sz;
    @(posedge clk); #1;
    sel = 1'b0; trans = 2'd0; wdata = wd;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy) break;
      lows++;
    end
    if (lows >= 20) chk("ready_timeout", 32'(lows), 32'd0);
    rd = rdo;
    rs = rsp;
    @(posedge clk); #1;
  endtask

  // Write immediately followed by a pipelined read (zero wait states only).
  task automatic wr_then_rd(input string tag, input logic [31:0] aw, input logic [2:0] sz,
                            input logic [31:0] wd, input logic [31:0] ar,
                            input logic [31:0] exp);
    sel = 1'b1; trans = 2'd2; write = 1'b1; addr = aw; size = sz;
    @(posedge clk); #1;
    wdata = wd; write = 1'b0; addr = ar; size = 3'd2; trans = 2'd2;
    @(negedge clk);
    chk({tag, "_wr_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_wr_resp"}, 32'(rsp), 32'd0);
    @(posedge clk); #1;
    sel = 1'b0; trans = 2'd0;
    @(negedge clk);
    chk({tag, "_rd_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_rd_resp"}, 32'(rsp), 32'd0);
    chk({tag, "_rd_data"}, rdo, exp);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        rs;
  int          lows;

  initial begin
    // Reset state of all three instances
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tgt = 2'(k);
      #0;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_resp", 32'(rsp), 32'd0);
      chk("rst_rdata", rdo, 32'd0);
    end
    tgt = 2'd0;
    @(posedge clk); #1;

    // Zero wait states: word write then read, back-to-back
    wr_then_rd("wr_rd_10", 32'h10, 3'd2, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF);

    // Sub-word writes merge into one word
    single(1'b1, 32'h0, 3'd2, 32'h0000_0000, rd, rs, lows);
    single(1'b1, 32'h3, 3'd0, 32'hAA00_0000, rd, rs, lows);
    single(1'b1, 32'h0, 3'd1, 32'h0000_1234, rd, rs, lows);
    single(1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lows);
    chk("merge_rdata", rd, 32'hAA001234);
    chk("merge_lows", 32'(lows), 32'd0);

    // Forwarding: full word, then a single byte into a preloaded word
    wr_then_rd("fwd_20", 32'h20, 3'd2, 32'h11223344, 32'h20, 32'h11223344);
    single(1'b1, 32'h30, 3'd2, 32'h55667788, rd, rs, lows);
    wr_then_rd("fwd_byte", 32'h31, 3'd0, 32'h0000_9900, 32'h30, 32'h55669988);

    // Illegal accesses: two-cycle ERROR, memory untouched
    single(1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF, rd, rs, lows);
    chk("mis_word_resp", 32'(rs), 32'd1);
    chk("mis_word_lows", 32'(lows), 32'd1);
    single(1'b1, 32'h1, 3'd1, 32'hFFFF_FFFF, rd, rs, lows);
    chk("mis_half_resp", 32'(rs), 32'd1);
    single(1'b1, 32'h0, 3'd3, 32'hFFFF_FFFF, rd, rs, lows);
    chk("size3_resp", 32'(rs), 32'd1);
    chk("size3_lows", 32'(lows), 32'd1);
    single(1'b1, 32'h800, 3'd2, 32'hFFFF_FFFF, rd, rs, lows);
    chk("range_wr_resp", 32'(rs), 32'd1);
    single(1'b0, 32'h800, 3'd2, 32'h0, rd, rs, lows);
    chk("range_rd_resp", 32'(rs), 32'd1);
    chk("range_rd_lows", 32'(lows), 32'd1);
    single(1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lows);
    chk("err_mem_kept", rd, 32'hAA001234);
    chk("err_ok_resp", 32'(rs), 32'd0);

    // Three wait states
    tgt = 2'd1;
    single(1'b1, 32'h4, 3'd2, 32'h0BADF00D, rd, rs, lows);
    chk("ws3_wr_lows", 32'(lows), 32'd3);
    single(1'b0, 32'h4, 3'd2, 32'h0, rd, rs, lows);
    chk("ws3_rd_lows", 32'(lows), 32'd3);
    chk("ws3_rd_data", rd, 32'h0BADF00D);
    chk("ws3_rd_resp", 32'(rs), 32'd0);

    // IDLE and BUSY with sel high: no transfer
    for (int t = 0; t < 2; t++) begin
      sel = 1'b1; trans = 2'(t); write = 1'b1; addr = 32'h4; size = 3'd2;
      @(posedge clk); #1;
      wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("idlebusy_ready", 32'(rdy), 32'd1);
      chk("idlebusy_resp", 32'(rsp), 32'd0);
      @(posedge clk); #1;
    end
    sel = 1'b0; trans = 2'd0;
    single(1'b0, 32'h4, 3'd2, 32'h0, rd, rs, lows);
    chk("idlebusy_mem", rd, 32'h0BADF00D);

    // Reset during the wait state of a write
    tgt = 2'd2;
    single(1'b1, 32'h8, 3'd2, 32'h12345678, rd, rs, lows);
    chk("ws2_wr_lows", 32'(lows), 32'd2);
    single(1'b0, 32'h8, 3'd2, 32'h0, rd, rs, lows);
    chk("ws2_pre_rd", rd, 32'h12345678);
    sel = 1'b1; trans = 2'd2; write = 1'b1; addr = 32'h8; size = 3'd2;
    @(posedge clk); #1;
    sel = 1'b0; trans = 2'd0; wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("midrst_wait_ready", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy), 32'd1);
    chk("midrst_resp", 32'(rsp), 32'd0);
    chk("midrst_rdata", rdo, 32'd0);
    @(posedge clk); #1;
    single(1'b0, 32'h8, 3'd2, 32'h0, rd, rs, lows);
    chk("midrst_mem_kept", rd, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
